sa_matmul_engine: RTL

//  Parametrised output-stationary SIZE x SIZE fixed-point systolic matmul engine. Computes C = A*B over a runtime reduction length K.

---
 rtl/sa_pkg.sv | 10 +
 rtl/sa_pe_acc.sv | 36 +++
 rtl/sa_matmul_engine.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding and width helpers for the systolic matmul engine
package sa_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  function automatic int prod_w(int dw);
    return 2 * dw;
  endfunction
  function automatic int idx_w(int size);
    return size > 1 ? $clog2(size) : 1;
  endfunction
endpackage

// File: rtl/sa_pe_acc.sv
// sa_pe_acc: one processing element with operand pass registers and a wrap/saturate accumulator
module sa_pe_acc
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] up_in,
  output logic [DATA_WIDTH-1:0] left_out,
  output logic [DATA_WIDTH-1:0] up_out,
  output logic [DATA_WIDTH-1:0] acc
);
  localparam int PW = prod_w(DATA_WIDTH);
  logic [PW-1:0] prod;
  logic [DATA_WIDTH-1:0] term;
  logic [DATA_WIDTH:0] sum;
  assign prod = PW'(left_in) * PW'(up_in);
  assign term = DATA_WIDTH'(prod >> FRAC_BITS);
  assign sum  = {1'b0, acc} + {1'b0, term};
  always_ff @(posedge clk)
    if (rst || clr) begin
      left_out <= '0;
      up_out   <= '0;
      acc      <= '0;
    end else if (adv) begin
      left_out <= left_in;
      up_out   <= up_in;
      acc      <= (SATURATE != 0 && sum[DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/sa_matmul_engine.sv
// sa_matmul_engine: output-stationary SIZE x SIZE systolic matmul with skew, job FSM and row drain
module sa_matmul_engine
  import sa_pkg::*;
#(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int K_WIDTH    = 8,
  parameter int SATURATE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [K_WIDTH-1:0]         k_len,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE*DATA_WIDTH-1:0] in_left,
  input  logic [SIZE*DATA_WIDTH-1:0] in_up,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE*DATA_WIDTH-1:0] out_row,
  output logic [idx_w(SIZE)-1:0]     out_row_idx
);
  localparam int DW = DATA_WIDTH;
  localparam int IW = idx_w(SIZE);
  localparam int FW = $clog2(2 * SIZE);
  state_t state, state_n;
  logic done_n, adv, clr;
  logic [K_WIDTH-1:0] k_q, k_cnt;
  logic [FW-1:0] f_cnt;
  logic [IW-1:0] idx;
  logic [DW-1:0] lh [SIZE][SIZE+1];
  logic [DW-1:0] uv [SIZE+1][SIZE];
  logic [DW-1:0] acc [SIZE][SIZE];
  logic [DW-1:0] unused_r [SIZE];
  logic [DW-1:0] unused_d [SIZE];
  assign busy        = state != IDLE;
  assign in_ready    = state == LOAD;
  assign out_valid   = state == DRAIN;
  assign out_row_idx = idx;
  assign adv         = (state == LOAD && in_valid) || state == FLUSH;
  assign clr         = state == IDLE && start;
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      IDLE:    if (start) state_n = k_len == '0 ? DRAIN : LOAD;
      LOAD:    if (in_valid && k_cnt == k_q - K_WIDTH'(1)) state_n = FLUSH;
      FLUSH:   if (f_cnt == FW'(2 * SIZE - 2)) state_n = DRAIN;
      DRAIN:   if (out_ready && idx == IW'(SIZE - 1)) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      k_q   <= '0;
      k_cnt <= '0;
      f_cnt <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (clr) begin
        k_q   <= k_len;
        k_cnt <= '0;
        f_cnt <= '0;
        idx   <= '0;
      end
      if (state == LOAD && in_valid) k_cnt <= k_cnt + K_WIDTH'(1);
      if (state == FLUSH) f_cnt <= f_cnt + FW'(1);
      if (state == DRAIN && out_ready) idx <= idx == IW'(SIZE - 1) ? '0 : idx + IW'(1);
    end
  // lane i enters the array i advances late so operands meet on the anti-diagonal
  for (genvar i = 0; i < SIZE; i++) begin : g_skew
    logic [DW-1:0] l_src, u_src;
    assign l_src = state == LOAD ? in_left[(i+1)*DW-1 -: DW] : '0;
    assign u_src = state == LOAD ? in_up[(i+1)*DW-1 -: DW] : '0;
    if (i == 0) begin : g_d0
      assign lh[0][0] = l_src;
      assign uv[0][0] = u_src;
    end else begin : g_dn
      logic [DW-1:0] lq [i];
      logic [DW-1:0] uq [i];
      always_ff @(posedge clk)
        if (rst || clr) begin
          for (int k = 0; k < i; k++) begin
            lq[k] <= '0;
            uq[k] <= '0;
          end
        end else if (adv) begin
          lq[0] <= l_src;
          uq[0] <= u_src;
          for (int k = 1; k < i; k++) begin
            lq[k] <= lq[k-1];
            uq[k] <= uq[k-1];
          end
        end
      assign lh[i][0] = lq[i-1];
      assign uv[0][i] = uq[i-1];
    end
    assign unused_r[i] = lh[i][SIZE];
    assign unused_d[i] = uv[SIZE][i];
  end
  for (genvar r = 0; r < SIZE; r++) begin : g_row
    for (genvar c = 0; c < SIZE; c++) begin : g_col
      sa_pe_acc #(.DATA_WIDTH(DW), .FRAC_BITS(FRAC_BITS), .SATURATE(SATURATE)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .adv      (adv),
        .clr      (clr),
        .left_in  (lh[r][c]),
        .up_in    (uv[r][c]),
        .left_out (lh[r][c+1]),
        .up_out   (uv[r+1][c]),
        .acc      (acc[r][c])
      );
    end
  end
  for (genvar c = 0; c < SIZE; c++) begin : g_out
    assign out_row[(c+1)*DW-1 -: DW] = state == DRAIN ? acc[idx][c] : '0;
  end
endmodule
